typing_round_ctrl: RTL

//   Round controller for the typing tutor, replacing the single-digit register/compare path.

---
 rtl/typing_round_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/typing_round_ctrl.sv
// Typing tutor round controller: scan-code filter, target load,
// cursor/score/miss tracking and per-round timeout.
module typing_round_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int SCORE_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_valid,
    input  logic [7:0]              scan_code,
    input  logic [3:0]              rand_nibble,
    output logic [4*NUM_DIGITS-1:0] target_digits,
    output logic [1:0]              cursor,
    output logic [SCORE_W-1:0]      score,
    output logic [SCORE_W-1:0]      misses,
    output logic                    busy,
    output logic                    round_done,
    output logic                    timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    state_t state, state_d;

    logic          break_pend, ext_pend;
    logic          is_prefix, make_valid;
    logic          is_digit, digit_hit, esc_hit;
    logic [3:0]    key_val, cur_tgt, rnd_bcd;
    logic          correct, wrong, expire;
    logic [1:0]    cursor_d, load_cnt, load_cnt_d;
    logic [TW-1:0] timer, timer_d;
    logic [SCORE_W-1:0] score_d, misses_d;
    logic          done_d, tmo_d, load_wr;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v
    );
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    assign is_prefix  = (scan_code == 8'hF0) || (scan_code == 8'hE0);
    assign make_valid = scan_valid && !is_prefix
                        && !break_pend && !ext_pend;
    assign digit_hit  = make_valid && is_digit;
    assign esc_hit    = make_valid && (scan_code == 8'h76);
    assign rnd_bcd    = (rand_nibble > 4'd9) ? rand_nibble - 4'd10
                                             : rand_nibble;
    assign correct    = digit_hit && (key_val == cur_tgt);
    assign wrong      = digit_hit && (key_val != cur_tgt);
    assign expire     = (timer == T_LAST);
    assign busy       = (state != IDLE);

    // Track break/extended prefixes; the byte after one is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hF0) begin
                break_pend <= 1'b1;
            end else if (scan_code == 8'hE0) begin
                ext_pend <= 1'b1;
            end else begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end
        end
    end

    // Set-2 make code to decimal digit.
    always_comb begin
        is_digit = 1'b1;
        key_val  = 4'd0;
        case (scan_code)
            8'h45:   key_val = 4'd0;
            8'h16:   key_val = 4'd1;
            8'h1E:   key_val = 4'd2;
            8'h26:   key_val = 4'd3;
            8'h25:   key_val = 4'd4;
            8'h2E:   key_val = 4'd5;
            8'h36:   key_val = 4'd6;
            8'h3D:   key_val = 4'd7;
            8'h3E:   key_val = 4'd8;
            8'h46:   key_val = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Select the target digit under the cursor.
    always_comb begin
        cur_tgt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cursor == 2'(i)) begin
                cur_tgt = target_digits[4*i +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next counter/pulse values.
    always_comb begin
        state_d    = state;
        cursor_d   = cursor;
        score_d    = score;
        misses_d   = misses;
        timer_d    = timer;
        load_cnt_d = load_cnt;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        load_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (esc_hit) begin
                    score_d  = '0;
                    misses_d = '0;
                end else if (digit_hit) begin
                    state_d    = LOAD;
                    load_cnt_d = 2'd0;
                    cursor_d   = 2'd0;
                    timer_d    = '0;
                end
            end
            LOAD: begin
                load_wr    = 1'b1;
                load_cnt_d = load_cnt + 2'd1;
                if (load_cnt == LAST) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                timer_d = timer + TW'(1);
                if (esc_hit) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (correct && cursor == LAST) begin
                    score_d    = sat_inc(score);
                    done_d     = 1'b1;
                    state_d    = LOAD;
                    load_cnt_d = 2'd0;
                    cursor_d   = 2'd0;
                    timer_d    = '0;
                end else begin
                    if (correct) begin
                        cursor_d = cursor + 2'd1;
                    end
                    if (wrong || expire) begin
                        misses_d = sat_inc(misses);
                    end
                    if (expire) begin
                        tmo_d      = 1'b1;
                        state_d    = LOAD;
                        load_cnt_d = 2'd0;
                        cursor_d   = 2'd0;
                        timer_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, timer and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor     <= 2'd0;
            score      <= '0;
            misses     <= '0;
            timer      <= '0;
            load_cnt   <= 2'd0;
            round_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cursor     <= cursor_d;
            score      <= score_d;
            misses     <= misses_d;
            timer      <= timer_d;
            load_cnt   <= load_cnt_d;
            round_done <= done_d;
            timeout    <= tmo_d;
        end
    end

    // Targets only change while loading, one digit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_digits <= '0;
        end else if (load_wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (load_cnt == 2'(i)) begin
                    target_digits[4*i +: 4] <= rnd_bcd;
                end
            end
        end
    end

endmodule
